// File: rtl/pc_ir_psw_unit.sv
// PC/IR/ALUOut/PSW register stage for the multicycle core: branch resolution, next-PC and memory-address muxing.
// Latency: registers update 1 cycle after their enables; mem_addr is combinational. No backpressure; the controller sequences the enables.
// Optional retired-instruction counter is enabled by defining PERF_CNT_EN; otherwise instr_cnt is tied to 0.
module pc_ir_psw_unit #(
    parameter int          W        = 16,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pc_write,
    input  logic         branch,
    input  logic [1:0]   pc_src,
    input  logic         ir_write,
    input  logic         iord,
    input  logic         psw_en,
    input  logic [W-1:0] alu_result,
    input  logic         alu_c,
    input  logic [W-1:0] reg_rs,
    input  logic [W-1:0] mem_rdata,
    output logic [W-1:0] opcode,
    output logic [W-1:0] pc,
    output logic [W-1:0] alu_out,
    output logic [W-1:0] mem_addr,
    output logic         psw_c,
    output logic         psw_z,
    output logic [W-1:0] instr_cnt
);

    logic         cond;
    logic         pc_load;
    logic [W-1:0] next_pc;

    // Condition is evaluated on the registered PSW, so a same-cycle psw_en sees old flags.
    always_comb begin
        cond = 1'b0;
        unique case (opcode[11:8])
            4'b0000: cond = psw_z;
            4'b0001: cond = ~psw_z;
            4'b0010: cond = psw_c;
            4'b0011: cond = ~psw_c;
            4'b1110: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = alu_result;
        unique case (pc_src)
            2'b00: next_pc = alu_result;
            2'b01: next_pc = alu_out;
            2'b10: next_pc = {pc[W-1:11], opcode[10:0]};
            2'b11: next_pc = reg_rs;
            default: next_pc = alu_result;
        endcase
    end

    assign pc_load  = pc_write | (branch & cond);
    assign mem_addr = iord ? alu_out : pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            opcode  <= '0;
            alu_out <= '0;
            psw_c   <= 1'b0;
            psw_z   <= 1'b0;
        end else begin
            alu_out <= alu_result;
            if (pc_load)
                pc <= next_pc;
            if (ir_write)
                opcode <= mem_rdata;
            if (psw_en) begin
                psw_c <= alu_c;
                psw_z <= (alu_result == '0);
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [W-1:0] cnt_q;

    // Saturates rather than wraps so a long run never reports a small count.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (ir_write && (cnt_q != {W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_ir_psw_unit.sv
// Directed-vector bench for pc_ir_psw_unit.
module tb_pc_ir_psw_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write, branch, ir_write, iord, psw_en, alu_c;
    logic [1:0]  pc_src;
    logic [15:0] alu_result, reg_rs, mem_rdata;
    logic [15:0] opcode, pc, alu_out, mem_addr, instr_cnt;
    logic        psw_c, psw_z;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_cnt = 16'h0;

    pc_ir_psw_unit #(.W(16), .RESET_PC(16'h0)) dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .branch(branch),
        .pc_src(pc_src), .ir_write(ir_write), .iord(iord), .psw_en(psw_en),
        .alu_result(alu_result), .alu_c(alu_c), .reg_rs(reg_rs),
        .mem_rdata(mem_rdata), .opcode(opcode), .pc(pc), .alu_out(alu_out),
        .mem_addr(mem_addr), .psw_c(psw_c), .psw_z(psw_z), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; the counter model tracks the pulses seen at that edge.
    task automatic step();
`ifdef PERF_CNT_EN
        if (!rst_n)
            exp_cnt = 16'h0;
        else if (ir_write && exp_cnt != 16'hFFFF)
            exp_cnt = exp_cnt + 16'h1;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_write = 0; branch = 0; ir_write = 0; psw_en = 0; iord = 0; pc_src = 2'b00;
    endtask

    initial begin
        rst_n = 1; alu_c = 0; alu_result = 0; reg_rs = 0; mem_rdata = 0;
        idle();
        #2;

        // Reset dominates with every enable high
        rst_n = 0; pc_write = 1; branch = 1; ir_write = 1; psw_en = 1;
        mem_rdata = 16'hFFFF; alu_result = 16'h1234; alu_c = 1;
        step();
        check("rst_pc", pc, 16'h0000);
        check("rst_opcode", opcode, 16'h0000);
        check("rst_alu_out", alu_out, 16'h0000);
        check("rst_psw_c", {15'h0, psw_c}, 16'h0);
        check("rst_psw_z", {15'h0, psw_z}, 16'h0);
        check("rst_cnt", instr_cnt, 16'h0000);
        rst_n = 1; idle();

        // Set PC to 0x0010
        pc_write = 1; alu_result = 16'h0010; alu_c = 0;
        step();
        check("pc_load", pc, 16'h0010);

        // Fetch: IR gets word at old PC, PC advances together
        idle(); ir_write = 1; pc_write = 1; mem_rdata = 16'hC005; alu_result = 16'h0011;
        #1;
        check("fetch_mem_addr", mem_addr, 16'h0010);
        step();
        check("fetch_opcode", opcode, 16'hC005);
        check("fetch_pc", pc, 16'h0011);

        // Flags latch then hold
        idle(); psw_en = 1; alu_result = 16'h0000; alu_c = 1;
        step();
        check("flag_z_set", {15'h0, psw_z}, 16'h1);
        check("flag_c_set", {15'h0, psw_c}, 16'h1);
        check("flag_pc_hold", pc, 16'h0011);
        idle(); alu_result = 16'h0005; alu_c = 0;
        step();
        check("flag_z_hold", {15'h0, psw_z}, 16'h1);
        check("flag_c_hold", {15'h0, psw_c}, 16'h1);
        check("alu_out_track", alu_out, 16'h0005);

        // BEQ taken to ALUOut
        alu_result = 16'h0040;
        step();
        iord = 1;
        #1;
        check("mem_addr_iord", mem_addr, 16'h0040);
        iord = 0; branch = 1; pc_src = 2'b01; alu_result = 16'h0099;
        step();
        check("beq_taken", pc, 16'h0040);

        // Clear Z (and C), then BEQ not taken
        idle(); psw_en = 1; alu_result = 16'h0001; alu_c = 0;
        step();
        check("flag_z_clr", {15'h0, psw_z}, 16'h0);
        idle(); branch = 1; alu_result = 16'h0077;
        step();
        check("beq_not_taken", pc, 16'h0040);

        // psw_en with branch: branch sees old Z=0, Z becomes 1
        idle(); branch = 1; psw_en = 1; alu_result = 16'h0000; alu_c = 0;
        step();
        check("same_edge_pc", pc, 16'h0040);
        check("same_edge_z", {15'h0, psw_z}, 16'h1);

        // Undefined condition code 5
        idle(); ir_write = 1; mem_rdata = 16'hC512;
        step();
        check("ir_c512", opcode, 16'hC512);
        idle(); branch = 1; alu_result = 16'h0123;
        step();
        check("undef_cond", pc, 16'h0040);

        // BAL
        idle(); ir_write = 1; mem_rdata = 16'h0E00;
        step();
        idle(); branch = 1; alu_result = 16'h0200;
        step();
        check("bal_taken", pc, 16'h0200);

        // BCC taken (C=0), BCS not taken
        idle(); ir_write = 1; mem_rdata = 16'h0300;
        step();
        idle(); branch = 1; alu_result = 16'h0300;
        step();
        check("bcc_taken", pc, 16'h0300);
        idle(); ir_write = 1; mem_rdata = 16'h0200;
        step();
        idle(); branch = 1; alu_result = 16'h0500;
        step();
        check("bcs_not_taken", pc, 16'h0300);

        // JMP and JR
        idle(); ir_write = 1; pc_write = 1; mem_rdata = 16'h8345; alu_result = 16'h1234;
        step();
        check("jmp_setup_pc", pc, 16'h1234);
        idle(); pc_write = 1; pc_src = 2'b10; alu_result = 16'h0000;
        step();
        check("jmp_pc", pc, 16'h1345);
        idle(); pc_write = 1; pc_src = 2'b11; reg_rs = 16'hBEEF;
        step();
        check("jr_pc", pc, 16'hBEEF);

        // PC wraps via the ALU result
        idle(); pc_write = 1; alu_result = 16'hFFFF;
        step();
        idle(); pc_write = 1; alu_result = 16'hFFFF + 16'h1;
        step();
        check("pc_wrap", pc, 16'h0000);
        check("cnt_mid", instr_cnt, exp_cnt);

        // Reset mid-instruction discards everything
        idle(); pc_write = 1; ir_write = 1; psw_en = 1; alu_result = 16'h0000;
        alu_c = 1; mem_rdata = 16'hAAAA; rst_n = 0;
        step();
        check("rst2_pc", pc, 16'h0000);
        check("rst2_opcode", opcode, 16'h0000);
        check("rst2_z", {15'h0, psw_z}, 16'h0);
        check("rst2_cnt", instr_cnt, 16'h0000);
        rst_n = 1; idle();

        // Counter: 3 pulses, then run to saturation
        ir_write = 1;
        repeat (3) step();
`ifdef PERF_CNT_EN
        check("cnt_three", instr_cnt, 16'h0003);
        repeat (65535) step();
        check("cnt_sat", instr_cnt, 16'hFFFF);
        repeat (2) step();
        check("cnt_sat_hold", instr_cnt, 16'hFFFF);
`else
        check("cnt_tied", instr_cnt, 16'h0000);
`endif
        check("cnt_model", instr_cnt, exp_cnt);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
